layer_compositor: RTL and testbench

- Parametrised successor to the fixed image/palette/overlay fusion path in the GPU.
- Fetches one display row from NUM_LAYERS time-multiplexed VRAM layers, bottom (layer 0) to top (layer NUM_LAYERS-1).
- Merges each layer into a row accumulator; a pixel equal to KEY is transparent. Disabled layers are skipped.
- Delivers the composed row to one of two row caches with a one-cycle load pulse. Sits between the VRAM read port and row_cache, driven by read_memory_management.

---
 rtl/layer_compositor.sv | 136 +++++++++++++
 tb/tb_layer_compositor.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_compositor.sv
// Composes one display row from NUM_LAYERS VRAM layers, bottom to top, with
// KEY-transparent pixels, then hands the row to one of two row caches.
module layer_compositor #(
   parameter int NUM_LAYERS = 3,
   parameter int COLS = 64,
   parameter int PX_W = 8,
   parameter int ROW_W = 6,
   parameter logic [PX_W-1:0] KEY = '0,
   parameter int TIMEOUT = 255,
   localparam int SEL_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   in_req,
   input  logic [ROW_W-1:0]       in_row,
   input  logic                   in_target,
   input  logic [NUM_LAYERS-1:0]  in_layer_en,
   input  logic [PX_W-1:0]        in_bg_color,
   output logic                   out_rd,
   output logic [ROW_W-1:0]       out_rd_addr,
   output logic [SEL_W-1:0]       out_layer_sel,
   input  logic [COLS*PX_W-1:0]   in_rd_data,
   input  logic                   in_rd_valid,
   output logic [COLS*PX_W-1:0]   out_data,
   output logic                   out_load0,
   output logic                   out_load1,
   output logic                   out_busy,
   output logic                   out_done,
   output logic                   out_err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, WRITE, DONE} state_t;

   state_t                 state, state_n;
   logic [ROW_W-1:0]       row_q;
   logic                   target_q;
   logic [NUM_LAYERS-1:0]  en_q;
   logic [SEL_W-1:0]       ptr;
   logic [COLS*PX_W-1:0]   acc;
   logic [TW-1:0]          tcnt;
   logic                   err_q;
   logic [SEL_W:0]         first_res, adv_res;
   logic                   timeout, resolve;

   // Returns {found, index} of the lowest enabled layer at or above start.
   function automatic logic [SEL_W:0] find_layer(input logic [NUM_LAYERS-1:0] en,
                                                  input int start);
      logic [SEL_W:0] res;
      res = '0;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (i >= start && en[i]) res = {1'b1, SEL_W'(i)};
      end
      return res;
   endfunction

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n   = state;
      first_res = find_layer(in_layer_en, 0);
      adv_res   = find_layer(en_q, int'(ptr) + 1);
      timeout   = 1'b0;
      resolve   = 1'b0;
      case (state)
         IDLE: begin
            if (in_req) state_n = first_res[SEL_W] ? FETCH : WRITE;
         end
         FETCH: state_n = WAIT;
         WAIT: begin
            timeout = !in_rd_valid && (tcnt == TW'(TIMEOUT - 1));
            resolve = in_rd_valid || timeout;
            if (resolve) state_n = adv_res[SEL_W] ? FETCH : WRITE;
         end
         WRITE: state_n = DONE;
         DONE:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Datapath: latched request fields, accumulator, layer pointer and timeout.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         row_q    <= '0;
         target_q <= 1'b0;
         en_q     <= '0;
         ptr      <= '0;
         acc      <= '0;
         tcnt     <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_req) begin
                  row_q    <= in_row;
                  target_q <= in_target;
                  en_q     <= in_layer_en;
                  ptr      <= first_res[SEL_W-1:0];
                  acc      <= {COLS{in_bg_color}};
                  err_q    <= 1'b0;
               end
            end
            FETCH: tcnt <= '0;
            WAIT: begin
               if (in_rd_valid) begin
                  for (int c = 0; c < COLS; c++) begin
                     if (in_rd_data[c*PX_W +: PX_W] != KEY)
                        acc[c*PX_W +: PX_W] <= in_rd_data[c*PX_W +: PX_W];
                  end
               end else if (timeout) begin
                  err_q <= 1'b1;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
               if (resolve && adv_res[SEL_W]) ptr <= adv_res[SEL_W-1:0];
            end
            default: ;
         endcase
      end
   end

   assign out_rd        = (state == FETCH);
   assign out_rd_addr   = row_q;
   assign out_layer_sel = ptr;
   assign out_data      = acc;
   assign out_load0     = (state == WRITE) && !target_q;
   assign out_load1     = (state == WRITE) && target_q;
   assign out_busy      = (state != IDLE);
   assign out_done      = (state == DONE);
   assign out_err       = err_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor: a VRAM responder answers reads, the
// monitor predicts each accepted request and checks the load/done it produces.
module tb_layer_compositor;

   localparam int NUM_LAYERS = 3;
   localparam int COLS = 64;
   localparam int PX_W = 8;
   localparam int ROW_W = 6;
   localparam int TIMEOUT = 255;
   localparam int SEL_W = 2;
   localparam int W = COLS * PX_W;
   localparam int RD_LAT = 1;
   localparam logic [PX_W-1:0] KEY = 8'h00;

   logic                   clk;
   logic                   rstn;
   logic                   in_req;
   logic [ROW_W-1:0]       in_row;
   logic                   in_target;
   logic [NUM_LAYERS-1:0]  in_layer_en;
   logic [PX_W-1:0]        in_bg_color;
   logic                   out_rd;
   logic [ROW_W-1:0]       out_rd_addr;
   logic [SEL_W-1:0]       out_layer_sel;
   logic [W-1:0]           in_rd_data;
   logic                   in_rd_valid;
   logic [W-1:0]           out_data;
   logic                   out_load0;
   logic                   out_load1;
   logic                   out_busy;
   logic                   out_done;
   logic                   out_err;

   layer_compositor #(
      .NUM_LAYERS(NUM_LAYERS), .COLS(COLS), .PX_W(PX_W), .ROW_W(ROW_W),
      .KEY(KEY), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rstn(rstn), .in_req(in_req), .in_row(in_row),
      .in_target(in_target), .in_layer_en(in_layer_en), .in_bg_color(in_bg_color),
      .out_rd(out_rd), .out_rd_addr(out_rd_addr), .out_layer_sel(out_layer_sel),
      .in_rd_data(in_rd_data), .in_rd_valid(in_rd_valid), .out_data(out_data),
      .out_load0(out_load0), .out_load1(out_load1), .out_busy(out_busy),
      .out_done(out_done), .out_err(out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] row;
      logic         tgt;
      int           lat;
      logic         err;
   } exp_t;

   exp_t                   sb[$];
   exp_t                   cur_exp;
   logic [W-1:0]           layer_data [NUM_LAYERS];
   bit [NUM_LAYERS-1:0]    mute;
   logic [NUM_LAYERS-1:0]  cur_en;
   int                     sel_log[$];
   int                     accept_log[$];
   int                     done_log[$];
   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int last_accept = 0;
   int rd_count = 0;
   int load_count = 0;
   int done_count = 0;
   int err_rise = 0;
   logic err_prev = 1'b0;

   always @(posedge clk) cyc++;

   task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0h, required %0h", tag, got, exp);
      end
   endtask

   // Reference composition: background fill, then every enabled layer in
   // ascending order overwrites non-KEY pixels; a silent layer costs a timeout.
   function automatic exp_t model(input logic [NUM_LAYERS-1:0] en,
                                  input logic [PX_W-1:0] bg, input logic tgt);
      exp_t r;
      logic [PX_W-1:0] px;
      r.row = {COLS{bg}};
      r.tgt = tgt;
      r.lat = 1;
      r.err = 1'b0;
      for (int l = 0; l < NUM_LAYERS; l++) begin
         if (en[l]) begin
            if (mute[l]) begin
               r.lat += 1 + TIMEOUT;
               r.err = 1'b1;
            end else begin
               r.lat += 1 + RD_LAT;
               for (int c = 0; c < COLS; c++) begin
                  px = layer_data[l][c*PX_W +: PX_W];
                  if (px != KEY) r.row[c*PX_W +: PX_W] = px;
               end
            end
         end
      end
      return r;
   endfunction

   // VRAM responder: valid for exactly one cycle, RD_LAT cycle after the strobe.
   initial begin : responder
      int sel_r;
      in_rd_valid = 1'b0;
      in_rd_data  = '0;
      forever begin
         @(negedge clk);
         if (rstn && out_rd) begin
            sel_r = int'(out_layer_sel);
            if (sel_r < NUM_LAYERS && !mute[sel_r]) begin
               @(posedge clk); #1;
               in_rd_data  = layer_data[sel_r];
               in_rd_valid = 1'b1;
               @(posedge clk); #1;
               in_rd_valid = 1'b0;
               in_rd_data  = {COLS{8'h5A}};
            end
         end
      end
   end

   // Monitor: predicts on accept, checks on load and done pulses.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (rstn) begin
            if (in_req && !out_busy) begin
               last_accept = cyc;
               accept_log.push_back(cyc);
               cur_en = in_layer_en;
               sb.push_back(model(in_layer_en, in_bg_color, in_target));
            end
            if (out_rd) begin
               rd_count++;
               sel_log.push_back(int'(out_layer_sel));
               checkOutput("rd_sel_enabled", W'(cur_en[out_layer_sel]), W'(1));
            end
            if (out_load0 || out_load1) begin
               load_count++;
               if (sb.size() == 0) begin
                  checkOutput("unexpected_load", W'(1), W'(0));
               end else begin
                  cur_exp = sb.pop_front();
                  checkOutput("load_data", out_data, cur_exp.row);
                  checkOutput("load_target", W'({out_load1, out_load0}),
                              W'({cur_exp.tgt, ~cur_exp.tgt}));
                  checkOutput("load_latency", W'(cyc - last_accept), W'(cur_exp.lat));
               end
            end
            if (out_done) begin
               done_count++;
               done_log.push_back(cyc);
               checkOutput("done_latency", W'(cyc - last_accept), W'(cur_exp.lat + 1));
               checkOutput("done_err", W'(out_err), W'(cur_exp.err));
               checkOutput("done_data", out_data, cur_exp.row);
            end
            if (out_err && !err_prev) err_rise = cyc;
         end
         err_prev = out_err;
      end
   end

   task automatic applyStimulus(input logic [NUM_LAYERS-1:0] en, input logic [PX_W-1:0] bg,
                                input logic tgt, input logic [ROW_W-1:0] row);
      in_layer_en = en;
      in_bg_color = bg;
      in_target   = tgt;
      in_row      = row;
      in_req      = 1'b1;
      @(posedge clk); #1;
      in_req      = 1'b0;
   endtask

   task automatic waitDone(input int target);
      int k;
      k = 0;
      while (done_count < target && k < 2000) begin
         @(posedge clk); #1;
         k++;
      end
      if (done_count < target) checkOutput("wait_done", W'(done_count), W'(target));
   endtask

   task automatic randomLayers();
      for (int l = 0; l < NUM_LAYERS; l++) begin
         for (int c = 0; c < COLS; c++) begin
            layer_data[l][c*PX_W +: PX_W] =
               ($urandom_range(0, 2) == 0) ? KEY : PX_W'($urandom_range(1, 255));
         end
      end
   endtask

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: observed no finish, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      int d, r, ld, a, k;
      rstn = 1'b0;
      in_req = 1'b0;
      in_row = '0;
      in_target = 1'b0;
      in_layer_en = '0;
      in_bg_color = '0;
      mute = '0;
      for (int l = 0; l < NUM_LAYERS; l++) layer_data[l] = '0;

      repeat (3) @(posedge clk); #1;
      checkOutput("reset_ctrl", W'({out_rd, out_busy, out_done, out_err, out_load0, out_load1,
                                    out_rd_addr, out_layer_sel}), W'(0));
      checkOutput("reset_data", out_data, '0);
      rstn = 1'b1;
      @(posedge clk); #1;

      $display("[TB] test 1: three layers, top layer wins");
      layer_data[0] = {COLS{8'h11}};
      layer_data[1] = '0;
      layer_data[1][0 +: PX_W] = 8'h22;
      layer_data[2] = '0;
      layer_data[2][5*PX_W +: PX_W] = 8'h33;
      d = done_count;
      applyStimulus(3'b111, 8'h55, 1'b0, 6'd9);
      waitDone(d + 1);
      checkOutput("t1_col0", W'(out_data[0 +: PX_W]), W'(8'h22));
      checkOutput("t1_col5", W'(out_data[5*PX_W +: PX_W]), W'(8'h33));
      checkOutput("t1_col1", W'(out_data[1*PX_W +: PX_W]), W'(8'h11));
      checkOutput("t1_col63", W'(out_data[63*PX_W +: PX_W]), W'(8'h11));
      checkOutput("t1_done_cycle", W'(done_log[done_log.size()-1] - last_accept), W'(8));
      checkOutput("t1_rd_addr", W'(out_rd_addr), W'(9));

      $display("[TB] test 2: no layers enabled");
      d = done_count;
      r = rd_count;
      applyStimulus(3'b000, 8'hAA, 1'b1, 6'd3);
      waitDone(d + 1);
      checkOutput("t2_no_rd", W'(rd_count), W'(r));
      checkOutput("t2_bg_fill", out_data, {COLS{8'hAA}});

      $display("[TB] test 3: sparse enables");
      sel_log.delete();
      d = done_count;
      applyStimulus(3'b101, 8'h07, 1'b0, 6'd40);
      waitDone(d + 1);
      checkOutput("t3_sel_count", W'(sel_log.size()), W'(2));
      if (sel_log.size() == 2) begin
         checkOutput("t3_sel_first", W'(sel_log[0]), W'(0));
         checkOutput("t3_sel_second", W'(sel_log[1]), W'(2));
      end

      $display("[TB] test 4: layer 1 never answers");
      mute[1] = 1'b1;
      d = done_count;
      applyStimulus(3'b111, 8'h44, 1'b0, 6'd17);
      waitDone(d + 1);
      checkOutput("t4_err_rise", W'(err_rise - last_accept), W'(259));
      checkOutput("t4_err_sticky", W'(out_err), W'(1));
      mute[1] = 1'b0;
      d = done_count;
      applyStimulus(3'b000, 8'h01, 1'b1, 6'd18);
      checkOutput("t4_err_clear", W'(out_err), W'(0));
      waitDone(d + 1);

      $display("[TB] test 5: reset during the second wait");
      ld = load_count;
      d = done_count;
      r = rd_count;
      applyStimulus(3'b111, 8'h66, 1'b0, 6'd21);
      k = 0;
      while (rd_count < r + 2 && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      checkOutput("t5_reached_wait2", W'(rd_count), W'(r + 2));
      #1;
      rstn = 1'b0;
      #1;
      checkOutput("t5_reset_ctrl", W'({out_rd, out_busy, out_done, out_err, out_load0, out_load1,
                                       out_rd_addr, out_layer_sel}), W'(0));
      checkOutput("t5_reset_data", out_data, '0);
      sb.delete();
      repeat (3) @(posedge clk); #1;
      checkOutput("t5_no_load", W'(load_count), W'(ld));
      checkOutput("t5_no_done", W'(done_count), W'(d));
      rstn = 1'b1;
      @(posedge clk); #1;
      d = done_count;
      applyStimulus(3'b111, 8'h66, 1'b1, 6'd22);
      waitDone(d + 1);

      $display("[TB] test 6: request held high");
      a = accept_log.size();
      d = done_count;
      in_layer_en = 3'b011;
      in_bg_color = 8'h3C;
      in_target   = 1'b1;
      in_row      = 6'd63;
      in_req      = 1'b1;
      k = 0;
      while (done_count < d + 2 && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      in_req = 1'b0;
      repeat (3) @(posedge clk); #1;
      checkOutput("t6_accepts", W'(accept_log.size() - a), W'(2));
      checkOutput("t6_dones", W'(done_count - d), W'(2));
      if (accept_log.size() >= a + 2 && done_log.size() >= d + 1)
         checkOutput("t6_reaccept_gap", W'(accept_log[a+1] - done_log[d]), W'(1));

      $display("[TB] test 7: random rows");
      for (int i = 0; i < 4; i++) begin
         randomLayers();
         d = done_count;
         applyStimulus(NUM_LAYERS'($urandom_range(0, 7)), PX_W'($urandom_range(0, 255)),
                       1'($urandom_range(0, 1)), ROW_W'($urandom_range(0, 63)));
         waitDone(d + 1);
      end

      checkOutput("sb_empty", W'(sb.size()), W'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
